// File: rtl/hp_seq_pkg.sv
// Purpose: shared types, pulse indices, fetch windows and length decode for the instruction sequencer.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package hp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  // Decoder length codes; codes 5..7 fall through to the 24-state length.
  typedef enum logic [2:0] {
    LEN_8  = 3'd0,
    LEN_10 = 3'd1,
    LEN_12 = 3'd2,
    LEN_14 = 3'd3,
    LEN_24 = 3'd4
  } inst_len_t;

  // Bit positions of the pulses within fsm_out (there is no pP).
  localparam int PA = 18;
  localparam int PB = 17;
  localparam int PC = 16;
  localparam int PD = 15;
  localparam int PE = 14;
  localparam int PF = 13;
  localparam int PG = 12;
  localparam int PH = 11;
  localparam int PI = 10;
  localparam int PJ = 9;
  localparam int PK = 8;
  localparam int PL = 7;
  localparam int PM = 6;
  localparam int PN = 5;
  localparam int PO = 4;
  localparam int PQ = 3;
  localparam int PR = 2;
  localparam int PS = 1;
  localparam int PT = 0;

  // Fetch-phase windows, inclusive state numbers.
  localparam logic [4:0] PC_RD_LO   = 5'd1;
  localparam logic [4:0] PC_RD_HI   = 5'd4;
  localparam logic [4:0] LD_INST_LO = 5'd2;
  localparam logic [4:0] LD_INST_HI = 5'd3;
  localparam logic [4:0] SEL_INC_LO = 5'd5;
  localparam logic [4:0] SEL_INC_HI = 5'd7;
  localparam logic [4:0] LD_PC_LO   = 5'd6;
  localparam logic [4:0] LD_PC_HI   = 5'd7;

  // The decoder length is only trusted once state 8 completes.
  localparam logic [4:0] LEN_LATCH_STATE = 5'd8;
  localparam logic [4:0] FINAL_MAX       = 5'd24;

  function automatic logic [4:0] len_to_final(input logic [2:0] code);
    case (code)
      LEN_8:   len_to_final = 5'd8;
      LEN_10:  len_to_final = 5'd10;
      LEN_12:  len_to_final = 5'd12;
      LEN_14:  len_to_final = 5'd14;
      LEN_24:  len_to_final = 5'd24;
      default: len_to_final = 5'd24;
    endcase
  endfunction

endpackage

// File: rtl/hp_seq_tick.sv
// Purpose: sequencer state-tick generator; SEQ_PRESCALE_EN selects a modulo-CLK_DIV prescaler, else tick is constant 1.
// Latency: tick is combinational from the prescaler register; tick_nxt predicts the following clock.
// Backpressure: none; clr restarts the prescale period.
module hp_seq_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

`ifdef SEQ_PRESCALE_EN
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;

  // Next prescaler count: wrap at the last clock of a state, restart on clr.
  always_comb begin
    div_d = CW'(div_q + 1'b1);
    if (clr || (div_q == LAST)) begin
      div_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick     = (div_q == LAST);
  assign tick_nxt = (div_d == LAST);
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, clr, 32'(CLK_DIV)};
  assign tick      = 1'b1;
  assign tick_nxt  = 1'b1;
`endif

endmodule

// File: rtl/hp_sequencer.sv
// Purpose: relay-computer instruction sequencer: state counter 1..24, pulse vector, fetch controls, run/step/halt.
// Latency: all outputs registered; state 1 appears one clock after run/step in IDLE. SEQ_PRESCALE_EN stretches each state to CLK_DIV clocks.
// Backpressure: none; run low finishes the current instruction, HALTED holds until reset.
module hp_sequencer #(
  parameter int NUM_STATES = 24,
  parameter int FSM_W      = 19,
  parameter int CLK_DIV    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [2:0]       inst_len,
  output logic [FSM_W-1:0] fsm_out,
  output logic [4:0]       state_num,
  output logic             sel_PC,
  output logic             mem_read,
  output logic             ld_INST,
  output logic             ld_INC,
  output logic             sel_INC,
  output logic             ld_PC,
  output logic             busy,
  output logic             halted,
  output logic             inst_done
);
  import hp_seq_pkg::*;

  seq_state_t       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       final_q, final_d;
  logic             is_final_q, is_final_d;
  logic [FSM_W-1:0] fsm_q, fsm_d;
  logic             sel_pc_q, sel_pc_d, mem_rd_q, mem_rd_d;
  logic             ld_inst_q, ld_inst_d, ld_inc_q, ld_inc_d;
  logic             sel_inc_q, sel_inc_d, ld_pc_q, ld_pc_d;
  logic             busy_q, busy_d, halted_q, halted_d, done_q, done_d;
  logic             start, tick, tick_nxt;

  hp_seq_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  // Control FSM and state counter: start, advance, and end-of-instruction routing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    final_d = final_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d = EXEC;
          cnt_d   = 5'd1;
          final_d = 5'(NUM_STATES);
          start   = 1'b1;
        end
      end
      EXEC: begin
        if (tick) begin
          if (is_final_q) begin
            if (halt_req) begin
              state_d = HALTED;
              cnt_d   = 5'd0;
            end else if (run) begin
              cnt_d   = 5'd1;
              final_d = 5'(NUM_STATES);
            end else begin
              state_d = IDLE;
              cnt_d   = 5'd0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LEN_LATCH_STATE) begin
              final_d = len_to_final(inst_len);
            end
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Output decode from the next counter value so every output lines up with state_num.
  // State 8 can be final before the length is latched, so it looks at the live code.
  always_comb begin
    is_final_d = (state_d == EXEC) &&
                 ((cnt_d == LEN_LATCH_STATE) ? (len_to_final(inst_len) == LEN_LATCH_STATE)
                                             : (cnt_d == final_d));
    fsm_d = '0;
    for (int k = 0; k < FSM_W; k++) begin
      fsm_d[FSM_W-1-k] = (cnt_d == 5'(k + 1));
    end
    sel_pc_d  = (cnt_d >= PC_RD_LO)   && (cnt_d <= PC_RD_HI);
    mem_rd_d  = sel_pc_d;
    ld_inst_d = (cnt_d >= LD_INST_LO) && (cnt_d <= LD_INST_HI);
    ld_inc_d  = ld_inst_d;
    sel_inc_d = (cnt_d >= SEL_INC_LO) && (cnt_d <= SEL_INC_HI);
    ld_pc_d   = (cnt_d >= LD_PC_LO)   && (cnt_d <= LD_PC_HI);
    busy_d    = (state_d == EXEC);
    halted_d  = (state_d == HALTED);
    done_d    = is_final_d && tick_nxt;
  end

  // State and output registers; reset clears everything on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      final_q    <= FINAL_MAX;
      is_final_q <= 1'b0;
      fsm_q      <= '0;
      sel_pc_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      ld_inst_q  <= 1'b0;
      ld_inc_q   <= 1'b0;
      sel_inc_q  <= 1'b0;
      ld_pc_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      final_q    <= final_d;
      is_final_q <= is_final_d;
      fsm_q      <= fsm_d;
      sel_pc_q   <= sel_pc_d;
      mem_rd_q   <= mem_rd_d;
      ld_inst_q  <= ld_inst_d;
      ld_inc_q   <= ld_inc_d;
      sel_inc_q  <= sel_inc_d;
      ld_pc_q    <= ld_pc_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      done_q     <= done_d;
    end
  end

  assign fsm_out   = fsm_q;
  assign state_num = cnt_q;
  assign sel_PC    = sel_pc_q;
  assign mem_read  = mem_rd_q;
  assign ld_INST   = ld_inst_q;
  assign ld_INC    = ld_inc_q;
  assign sel_INC   = sel_inc_q;
  assign ld_PC     = ld_pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign inst_done = done_q;

endmodule

// File: tb/tb_hp_sequencer.sv
// Purpose: directed bench for hp_sequencer: reset, step, back-to-back run, halt, mid-instruction reset.
// Latency: checks one clock per state (CLK_DIV clocks per state when SEQ_PRESCALE_EN is defined).
// Backpressure: none.
module tb_hp_sequencer;

`ifdef SEQ_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, run, step, halt_req;
  logic [2:0]  inst_len;
  logic [18:0] fsm_out;
  logic [4:0]  state_num;
  logic        sel_PC, mem_read, ld_INST, ld_INC, sel_INC, ld_PC;
  logic        busy, halted, inst_done;

  int nvec = 0;
  int nerr = 0;

  hp_sequencer #(.NUM_STATES(24), .FSM_W(19), .CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .inst_len  (inst_len),
    .fsm_out   (fsm_out),
    .state_num (state_num),
    .sel_PC    (sel_PC),
    .mem_read  (mem_read),
    .ld_INST   (ld_INST),
    .ld_INC    (ld_INC),
    .sel_INC   (sel_INC),
    .ld_PC     (ld_PC),
    .busy      (busy),
    .halted    (halted),
    .inst_done (inst_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_halted);
    chk({tag, ".state_num"}, 32'(state_num), 32'd0);
    chk({tag, ".fsm_out"},   32'(fsm_out),   32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".halted"},    32'(halted),    32'(exp_halted));
    chk({tag, ".inst_done"}, 32'(inst_done), 32'd0);
    chk({tag, ".fetch"},
        32'({sel_PC, mem_read, ld_INST, ld_INC, sel_INC, ld_PC}), 32'd0);
  endtask

  // Check states lo..hi in order, DIV clocks each; inst_done only on the last clock of done_at.
  task automatic walk(input int lo, input int hi, input int done_at);
    logic [18:0] one;
    logic [18:0] pulse;
    one = 19'd1;
    for (int s = lo; s <= hi; s++) begin
      pulse = (s <= 19) ? (one << (19 - s)) : 19'd0;
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("s%0d.state_num", s), 32'(state_num), 32'(s));
        chk($sformatf("s%0d.fsm_out", s),   32'(fsm_out),   32'(pulse));
        chk($sformatf("s%0d.sel_PC", s),    32'(sel_PC),    32'(s >= 1 && s <= 4));
        chk($sformatf("s%0d.mem_read", s),  32'(mem_read),  32'(s >= 1 && s <= 4));
        chk($sformatf("s%0d.ld_INST", s),   32'(ld_INST),   32'(s >= 2 && s <= 3));
        chk($sformatf("s%0d.ld_INC", s),    32'(ld_INC),    32'(s >= 2 && s <= 3));
        chk($sformatf("s%0d.sel_INC", s),   32'(sel_INC),   32'(s >= 5 && s <= 7));
        chk($sformatf("s%0d.ld_PC", s),     32'(ld_PC),     32'(s >= 6 && s <= 7));
        chk($sformatf("s%0d.busy", s),      32'(busy),      32'd1);
        chk($sformatf("s%0d.halted", s),    32'(halted),    32'd0);
        chk($sformatf("s%0d.inst_done", s), 32'(inst_done), 32'(s == done_at && c == DIV - 1));
        cyc();
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; inst_len = 3'd0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset then quiet inputs: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_idle("reset_idle", 1'b0);
    end

    // Single step, 8-state instruction, back to IDLE.
    step = 1'b1; inst_len = 3'd0;
    cyc();
    step = 1'b0;
    walk(1, 8, 8);
    chk_idle("after_step", 1'b0);
    cyc();
    chk_idle("after_step2", 1'b0);

    // Free run: 14 states then 24 states with no gap; the length is held after state 8.
    run = 1'b1; inst_len = 3'd3;
    cyc();
    walk(1, 9, 0);
    inst_len = 3'd4;
    walk(10, 14, 14);
    walk(1, 11, 0);
    run = 1'b0;
    walk(12, 24, 24);
    chk_idle("run_dropped", 1'b0);

    // Halt on the final state of a 10-state instruction; later run/step are ignored.
    run = 1'b1; inst_len = 3'd1;
    cyc();
    walk(1, 9, 0);
    halt_req = 1'b1;
    walk(10, 10, 10);
    chk_idle("halted", 1'b1);
    halt_req = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk_idle("halted_step", 1'b1);
    cyc();
    chk_idle("halted_run", 1'b1);
    reset = 1'b1; run = 1'b0;
    cyc();
    reset = 1'b0;
    chk_idle("halt_cleared", 1'b0);

    // Reset in the middle of an instruction.
    step = 1'b1; inst_len = 3'd4;
    cyc();
    step = 1'b0;
    walk(1, 5, 0);
    chk("mid.state_num", 32'(state_num), 32'd6);
    reset = 1'b1;
    cyc();
    chk_idle("mid_reset", 1'b0);
    reset = 1'b0;
    cyc();
    chk_idle("mid_reset_idle", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
